// File: rtl/keypad_scan_encoder_if.sv
// rtl/keypad_scan_encoder_if.sv - keypad matrix pins and encoded key outputs
interface keypad_scan_encoder_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] key_code;
    logic       pressed;

    modport master (input row, output col, output key_code, output pressed);
    modport slave  (output row, input col, input key_code, input pressed);
endinterface

// File: rtl/keypad_scan_encoder.sv
// rtl/keypad_scan_encoder.sv - 4x4 active-low keypad scanner, debouncer and key encoder
// Optional KEYPAD_GHOST_REJECT_EN: refuse presses that show more than one low row.
module keypad_scan_encoder #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 20000
) (
    input  logic                   clk,
    input  logic                   rst,
    keypad_scan_encoder_if.master  kp
);
    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CNT) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_DONE = DEB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t           state;
    logic [3:0]       row_s1, row_s2;
    logic [DIV_W-1:0] div_cnt;
    logic [DEB_W-1:0] deb_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       col_r;
    logic [3:0]       row_pat;
    logic [1:0]       row_idx;
    logic [7:0]       code_r;
    logic             pressed_r;

    function automatic logic [1:0] lowest_low(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [7:0] key_lut(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 8'h01;
            4'b00_01: return 8'h02;
            4'b00_10: return 8'h03;
            4'b00_11: return 8'hF0;
            4'b01_00: return 8'h04;
            4'b01_01: return 8'h05;
            4'b01_10: return 8'h06;
            4'b01_11: return 8'hF1;
            4'b10_00: return 8'h07;
            4'b10_01: return 8'h08;
            4'b10_10: return 8'h09;
            4'b10_11: return 8'hF2;
            4'b11_00: return 8'hE1;
            4'b11_01: return 8'h00;
            4'b11_10: return 8'hE0;
            default:  return 8'hF3;
        endcase
    endfunction

    logic [3:0] low_rows;
    logic       any_low, multi_low, sample_hit, press_match;

    assign low_rows  = ~row_s2;
    assign any_low   = |low_rows;
    assign multi_low = |(low_rows & (low_rows - 4'd1));

`ifdef KEYPAD_GHOST_REJECT_EN
    assign sample_hit  = any_low && !multi_low;
    assign press_match = (row_s2 == row_pat) && !multi_low;
`else
    assign sample_hit  = any_low;
    assign press_match = (row_s2 == row_pat);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            row_s1    <= 4'hF;
            row_s2    <= 4'hF;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            col_idx   <= 2'd0;
            col_r     <= 4'b1110;
            row_pat   <= 4'hF;
            row_idx   <= 2'd0;
            code_r    <= 8'hFF;
            pressed_r <= 1'b0;
        end else begin
            row_s1 <= kp.row;
            row_s2 <= row_s1;
            case (state)
                SCAN: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (sample_hit) begin
                            row_pat <= row_s2;
                            row_idx <= lowest_low(row_s2);
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_r   <= {col_r[2:0], col_r[3]};
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                DEB_PRESS: begin
                    if (!press_match) begin
                        deb_cnt <= '0;
                        col_idx <= col_idx + 2'd1;
                        col_r   <= {col_r[2:0], col_r[3]};
                        state   <= SCAN;
                    end else if (deb_cnt == DEB_DONE) begin
                        deb_cnt   <= '0;
                        code_r    <= key_lut(row_idx, col_idx);
                        pressed_r <= 1'b1;
                        state     <= HELD;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                // Only the accepted row matters while held; other rows cannot disturb the key.
                HELD: begin
                    if (row_s2[row_idx]) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (!row_s2[row_idx]) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_DONE) begin
                        deb_cnt   <= '0;
                        pressed_r <= 1'b0;
                        code_r    <= 8'hFF;
                        col_idx   <= col_idx + 2'd1;
                        col_r     <= {col_r[2:0], col_r[3]};
                        state     <= SCAN;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

    assign kp.col      = col_r;
    assign kp.key_code = code_r;
    assign kp.pressed  = pressed_r;
endmodule

// File: tb/tb_keypad_scan_encoder.sv
// tb/tb_keypad_scan_encoder.sv - scoreboard bench for keypad_scan_encoder (SCAN_DIV=4, DEBOUNCE_CNT=8)
module tb_keypad_scan_encoder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = '0;
    logic [3:0]  row_drv;
    int          tick = 0;
    int          t0 = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          mon_en = 1'b0;

    typedef struct {
        logic       p;
        logic [7:0] code;
        int         cyc;
    } ev_t;
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic       prev_p = 1'b0;
    logic [7:0] prev_code = 8'hFF;

    keypad_scan_encoder_if kif();

    keypad_scan_encoder #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tick <= tick + 1;

    // Switch matrix model: a closed key pulls its row low while its column is driven.
    always_comb begin
        row_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.col[c]) row_drv[r] = 1'b0;
    end
    assign kif.row = row_drv;

    function automatic int kidx(input int r, input int c);
        return r * 4 + c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, tick - t0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t0 = tick;
        mon_en = 1'b1;
    endtask

    task automatic wait_to(input int n);
        while (tick - t0 < n) @(negedge clk);
    endtask

    task automatic expect_ev(input logic p, input logic [7:0] code, input int cyc);
        exp_q.push_back('{p, code, cyc});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (kif.pressed !== prev_p) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_edge: pressed=%0b code=%02h at cycle %0d, no edge expected",
                             kif.pressed, kif.key_code, tick - t0);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (kif.pressed !== mon_e.p || kif.key_code !== mon_e.code || (tick - t0) != mon_e.cyc) begin
                        n_bad++;
                        $display("FAIL pressed_edge: got pressed=%0b code=%02h cycle=%0d expected pressed=%0b code=%02h cycle=%0d",
                                 kif.pressed, kif.key_code, tick - t0, mon_e.p, mon_e.code, mon_e.cyc);
                    end
                end
            end else if (kif.pressed === 1'b1 && kif.key_code !== prev_code) begin
                n_bad++;
                $display("FAIL code_stable: got %02h expected %02h while held", kif.key_code, prev_code);
            end
            prev_p    <= kif.pressed;
            prev_code <= kif.key_code;
        end
    end

    initial begin
        // Reset state and column rotation
        keys = '0;
        do_reset();
        wait_to(0);
        check("reset_col", 32'(kif.col), 32'h E);
        check("reset_code", 32'(kif.key_code), 32'hFF);
        check("reset_pressed", 32'(kif.pressed), 32'h0);
        wait_to(4);  check("col_slot1", 32'(kif.col), 32'hD);
        wait_to(8);  check("col_slot2", 32'(kif.col), 32'hB);
        wait_to(12); check("col_slot3", 32'(kif.col), 32'h7);
        wait_to(16); check("col_wrap", 32'(kif.col), 32'hE);

        // Key "5": sampled at cycle 8, released so the synchronized row is high from cycle 33
        keys = '0; keys[kidx(1,1)] = 1'b1;
        do_reset();
        expect_ev(1'b1, 8'h05, 17);
        expect_ev(1'b0, 8'hFF, 42);
        wait_to(30); keys = '0;
        wait_to(70);

        // Key "=" with a 3-cycle bounce during the first debounce attempt
        keys = '0; keys[kidx(3,2)] = 1'b1;
        do_reset();
        expect_ev(1'b1, 8'hE0, 41);
        expect_ev(1'b0, 8'hFF, 62);
        wait_to(13); keys = '0;
        wait_to(16); keys[kidx(3,2)] = 1'b1;
        wait_to(50); keys = '0;
        wait_to(70);

        // Key "+" with a 4-cycle release glitch that must not drop pressed
        keys = '0; keys[kidx(0,3)] = 1'b1;
        do_reset();
        expect_ev(1'b1, 8'hF0, 25);
        expect_ev(1'b0, 8'hFF, 62);
        wait_to(30); keys = '0;
        wait_to(34); keys[kidx(0,3)] = 1'b1;
        wait_to(40);
        check("glitch_pressed", 32'(kif.pressed), 32'h1);
        check("glitch_code", 32'(kif.key_code), 32'hF0);
        wait_to(50); keys = '0;
        wait_to(70);

        // Rows 0 and 2 low on column 0
        keys = '0; keys[kidx(0,0)] = 1'b1; keys[kidx(2,0)] = 1'b1;
        do_reset();
`ifndef KEYPAD_GHOST_REJECT_EN
        expect_ev(1'b1, 8'h01, 13);
        expect_ev(1'b0, 8'hFF, 32);
`endif
        wait_to(20); keys = '0;
        wait_to(40);
        check("two_row_pressed_after", 32'(kif.pressed), 32'h0);
        wait_to(70);

        // Reset while "C" is held
        keys = '0; keys[kidx(3,0)] = 1'b1;
        do_reset();
        expect_ev(1'b1, 8'hE1, 13);
        wait_to(20);
        check("c_held", 32'(kif.pressed), 32'h1);
        expect_ev(1'b0, 8'hFF, 21);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_col", 32'(kif.col), 32'hE);
        check("rst_mid_code", 32'(kif.key_code), 32'hFF);
        keys = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan_encoder.md
# keypad_scan_encoder

Scans a 4x4 active-low matrix keypad, debounces key press and release, and encodes the held key into the 8-bit key code plus level `pressed` consumed by `Calculator_fsm`. It is the producer end of the calculator's key interface: `key_code` drives the FSM's `in` and `pressed` drives its `pressed`. The FSM advances on the falling edge of `pressed`, so `pressed` must be glitch-free and held for the whole debounced press.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column stays driven; must be ≥2.
- `DEBOUNCE_CNT`, default 20000: consecutive stable cycles required to accept a press or a release; must be ≥1.
- `clk` input 1: single system clock; every flop runs on its rising edge.
- `rst` input 1: synchronous, active-high reset; takes priority over all other logic.
- `row` input 4: keypad rows, active-low; a row reads 0 when a key on the driven column is closed. Synchronized internally with 2 flops.
- `col` output 4: column drive, active-low, one-hot-zero; exactly one bit is 0 at all times.
- `key_code` output 8: encoded key while `pressed`=1; 8'hFF when idle.
- `pressed` output 1: high from debounced press until debounced release.

## Operation
- Key map (row r, col c):
  - r0: 1 2 3 +
  - r1: 4 5 6 -
  - r2: 7 8 9 *
  - r3: C 0 = /
- Codes:
  - digits 8'h00–8'h09
  - + 8'hF0, - 8'hF1, * 8'hF2, / 8'hF3
  - = 8'hE0 (Equ), C 8'hE1 (Clear)
  - idle 8'hFF
- States: SCAN, DEB_PRESS, HELD, DEB_REL.
- SCAN: `col` drives column c for `SCAN_DIV` cycles, in the order 0→1→2→3→0. Synchronized `row` is sampled only on the last cycle of each slot.
  - All rows high: advance to the next column.
  - Any row low: latch c and the row pattern, hold `col`, go to DEB_PRESS.
- DEB_PRESS: the counter increments each cycle the pattern equals the latched one.
  - Any mismatch: return to SCAN at the next column, counter cleared.
  - Counter reaches `DEBOUNCE_CNT`: go to HELD, register `key_code` and set `pressed`=1.
- Multiple low rows (macro off): the lowest-numbered low row wins.
- HELD: `col` stays held. When the latched row reads high, go to DEB_REL; other rows are ignored.
- DEB_REL: counts consecutive high samples of the latched row.
  - Row low again: return to HELD; `pressed` stays 1 with no glitch.
  - Count reaches `DEBOUNCE_CNT`: `pressed`=0, `key_code`=8'hFF, go to SCAN at the next column.
- While `pressed`=1, `key_code` never changes.
- Counter widths: `$clog2` of the parameter plus 1, with no wrap.

## Timing
- Reset values: `col`=4'b1110 (column 0), `key_code`=8'hFF, `pressed`=0, state SCAN, counters 0, synchronizers all 1s.
- Press latency: if synchronized `row` is low at sample cycle t and stays stable, `pressed` and `key_code` update at the clock edge ending cycle t+`DEBOUNCE_CNT`+1. Add 2 cycles for the raw pin through the synchronizer.
- Release latency: `pressed` falls `DEBOUNCE_CNT`+1 cycles after the first synchronized high sample, given stable input.
- `key_code` and `pressed` change on the same edge; they are never skewed.
- A bounce shorter than `DEBOUNCE_CNT` cycles produces no `pressed` activity.
- Reset asserted mid-press: outputs return to reset values on the next edge. `pressed` may drop without a release debounce; accepted, because the FSM resets on the same `rst`.

## Configuration
- `KEYPAD_GHOST_REJECT_EN` defined:
  - In the SCAN sample and throughout DEB_PRESS, more than one low row is treated as a mismatch, so no key is accepted.
  - In HELD, a second low row on the held column is ignored.
- Undefined: the lowest-numbered low row wins, as described under Operation.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CNT`=8.
- Reset → `col`=4'b1110, `key_code`=8'hFF, `pressed`=0; `col` then rotates 1101, 1011, 0111 every 4 cycles.
- Hold key "5" (r1,c1) stable → `pressed` rises 9 cycles after the c1 sample with `key_code`=8'h05; release → `pressed` falls 9 cycles after the first high sample, `key_code`=8'hFF.
- Press "=" with a 3-cycle bounce before stabilizing → single `pressed` pulse with 8'hE0, no early rise.
- Held "+" with a 4-cycle release glitch → `pressed` stays 1 with 8'hF0 throughout; rises once.
- r0 and r2 low on c0 → macro off: 8'h01; macro on: no `pressed`.
- `rst` asserted while "C" (8'hE1) is held → next edge `pressed`=0, `key_code`=8'hFF, `col`=4'b1110.
